clk_div_bank: RTL and testbench
===============================

# clk_div_bank

Multi-channel, runtime-programmable clock-enable/divided-clock generator for the QAM modulator clocking tree. It generalises the fixed single-output divider to `NCH` independent channels. Each channel has a divisor that can be changed at run time through a load handshake, and the change never produces a glitch. A common sync input phase-aligns all channels. It sits between the system clock input and the symbol-rate, DAC-rate and carrier-NCO consumers, which use either the divided clock level or the one-cycle enable strobe.

## Interface
- `NCH`, 4, number of independent divider channels (1..16)
- `WIDTH`, 13, divisor width in bits; divisor range 0..2^WIDTH-1
- `DEFAULT_DIV`, 13'd1, divisor loaded into every channel at reset
- `clk_in`  in  1  system clock; the only clock
- `rst_n`  in  1  asynchronous, active-low reset
- `div_load`  in  1  one-cycle request to load `div_val` into channel `div_ch`
- `div_ch`  in  $clog2(NCH) (min 1)  target channel index, sampled with `div_load`
- `div_val`  in  WIDTH  new divisor, sampled with `div_load`
- `div_busy`  out  1  a captured load is pending; further loads are ignored
- `div_ack`  out  1  one-cycle pulse in the cycle the pending divisor takes effect
- `sync`  in  1  one-cycle request to restart all channels at count 0
- `clk_out`  out  NCH  divided clock level per channel, registered
- `ce_out`  out  NCH  one-cycle enable strobe per channel, registered, coincident with `clk_out` rising

## Operation
- Per channel state: `cnt` (WIDTH bits) and `div` (WIDTH bits). In reset: `cnt` = 0, `div` = DEFAULT_DIV.
- Each edge, for channel i with `div` = D ≥ 2:
  - `clk_out[i]` <= (`cnt` < ceil(D/2))
  - `ce_out[i]` <= (`cnt` == 0)
  - `cnt` <= (`cnt` == D-1) ? 0 : `cnt`+1
- Duty cycle: high for ceil(D/2) cycles, low for floor(D/2). D=2 and D=4 give 50%; D=3 gives 2 high, 1 low.
- D=1: `clk_out[i]` = 1 and `ce_out[i]` = 1 every cycle after reset; `cnt` stays 0.
- D=0: channel disabled. `clk_out[i]` = 0, `ce_out[i]` = 0, `cnt` held 0.
- Load handshake:
  - `div_load` while `div_busy`=0 captures (`div_ch`, `div_val`) into a single shadow register and sets `div_busy` the next cycle.
  - `div_load` while `div_busy`=1 is dropped, with no effect.
  - `div_ch` ≥ NCH is dropped.
- Apply point for the pending divisor, which happens in the cycle the target channel's old `cnt` == D_old-1 (period boundary):
  - new `div` written, `cnt` <= 0, `div_ack` pulses, `div_busy` clears.
  - If the target has D_old ∈ {0,1}, the apply point is the first cycle after capture.
- `sync`: every channel `cnt` <= 0 on the next edge. `div` is unchanged. Outputs that edge are computed from the pre-sync `cnt`.
  - A load already pending is applied in the `sync` cycle (`div_ack` pulses).
  - A load arriving in the same cycle as `sync` is only captured; it applies at the next boundary.
- No divisor value produces a glitch: `clk_out` changes only on `clk_in` edges, from registered state.

## Timing
- Reset values: `clk_out` = 0, `ce_out` = 0, `div_busy` = 0, `div_ack` = 0. All are asynchronous clear.
- First edge after `rst_n` rises (D ≥ 1): `clk_out` = 1, `ce_out` = 1.
- Output latency: 1 cycle from counter state.
- Load latency:
  - capture to `div_busy`=1: 1 cycle
  - capture to `div_ack`: ≥ 1 cycle, at most D_old cycles
  - new period starts with `ce_out` on the edge after `div_ack`
- Reset asserted mid-load: the pending load is discarded and all channels return to DEFAULT_DIV.
- Counter wrap: at D = 2^WIDTH-1, `cnt` reaches 2^WIDTH-2 max. There is no overflow.

## Structure
- Package `clk_div_pkg`:
  - WIDTH default constant
  - function `half_ceil(d)` = (d+1)>>1, width WIDTH
  - localparam for channel-index width, min 1 bit
- Sub-module `clk_div_chan`: one channel.
  - Inputs: `cnt`/`div` state, `apply`, `new_div`, `sync`.
  - Outputs: `clk_out`, `ce_out`, `at_boundary`.
  - Instantiated NCH times by generate.
- The top level holds only the shadow register, busy/ack logic and channel decode.

## Test plan
- Reset release with DEFAULT_DIV=1, NCH=4, loads setting ch0..3 to 1, 2, 3, 4 -> steady-state `clk_out` periods are const-1, 2 (1H1L), 3 (2H1L), 4 (2H2L) cycles; `ce_out` pulses every 1, 2, 3, 4 cycles.
- Ch2 at D=5, load 7 mid-period at `cnt`=1 -> `div_ack` exactly 3 cycles after capture; no truncated high or low phase; next periods are 7 (4H3L).
- Load ch1 and a second load 1 cycle later -> second dropped; `div_busy` high until the single `div_ack`; ch1 holds the first value.
- Channels at D=3, 4, 6 running; pulse `sync` -> all `ce_out` coincide on the 2nd edge after `sync`, then repeat at LCM 12.
- Load D=0 into ch3 -> `clk_out[3]` and `ce_out[3]` = 0 from the edge after `div_ack`. Load D=2 later -> ack 1 cycle after capture, restart with `ce_out`.
- Assert `rst_n` low while `div_busy`=1 -> all outputs 0 immediately. After release, no `div_ack` fires and every channel runs at DEFAULT_DIV.

Source files
------------

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants and helpers for the clk_div_bank divider tree.
//   CDB_WIDTH   - default divisor width
//   CDB_NCH     - default channel count
//   chan_idx_w  - channel-index width, never below 1 bit
//   half_ceil   - length of the high phase, ceil(d/2)
package clk_div_pkg;

  localparam int CDB_WIDTH = 13;
  localparam int CDB_NCH   = 4;

  function automatic int chan_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Evaluated at 32 bits so d = 2^WIDTH-1 cannot overflow the +1.
  function automatic logic [31:0] half_ceil(input logic [31:0] d);
    return (d + 32'd1) >> 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel (counter, divisor, registered outputs).
//   clk_in/rst_n    - system clock, async active-low reset
//   i_apply         - write i_new_div and restart the period this edge
//   i_new_div       - divisor to install on i_apply
//   i_sync          - restart the period (cnt <= 0), divisor unchanged
//   o_clk_out       - divided clock level, high for ceil(D/2) of D cycles
//   o_ce_out        - one-cycle strobe at the start of each period
//   o_at_boundary   - current cycle is the last of the period (or D<=1)
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int               WIDTH       = CDB_WIDTH,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(1)
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             i_apply,
  input  logic [WIDTH-1:0] i_new_div,
  input  logic             i_sync,
  output logic             o_clk_out,
  output logic             o_ce_out,
  output logic             o_at_boundary
);

  logic [WIDTH-1:0] r_cnt, r_div;
  logic             r_clk, r_ce;
  logic [31:0]      w_half;
  logic             w_on, w_wrap;

  assign w_half = half_ceil(32'(r_div));
  assign w_on   = (r_div != '0);
  // D=0 and D=1 pin cnt at 0, so every cycle counts as a period boundary.
  assign w_wrap = (r_div < WIDTH'(2)) || (r_cnt == r_div - WIDTH'(1));

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_div <= DEFAULT_DIV;
      r_clk <= 1'b0;
      r_ce  <= 1'b0;
    end else begin
      // Outputs always come from the pre-update state, so an apply or sync
      // at the boundary never shortens the phase already being driven.
      r_clk <= w_on && (32'(r_cnt) < w_half);
      r_ce  <= w_on && (r_cnt == '0);
      if (i_apply) begin
        r_div <= i_new_div;
        r_cnt <= '0;
      end else if (i_sync || w_wrap) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + WIDTH'(1);
      end
    end
  end

  assign o_clk_out     = r_clk;
  assign o_ce_out      = r_ce;
  assign o_at_boundary = w_wrap;

endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank: NCH-channel runtime-programmable clock divider.
//   clk_in/rst_n          - system clock, async active-low reset
//   div_load/div_ch/div_val - load request; captured only when not busy
//   div_busy              - a captured load is waiting for its apply point
//   div_ack               - pulse in the cycle the new divisor is in effect
//   sync                  - restart every channel at count 0
//   clk_out/ce_out        - per-channel divided clock and period strobe
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int               NCH         = CDB_NCH,
  parameter int               WIDTH       = CDB_WIDTH,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(1)
) (
  input  logic                         clk_in,
  input  logic                         rst_n,
  input  logic                         div_load,
  input  logic [chan_idx_w(NCH)-1:0]   div_ch,
  input  logic [WIDTH-1:0]             div_val,
  output logic                         div_busy,
  output logic                         div_ack,
  input  logic                         sync,
  output logic [NCH-1:0]               clk_out,
  output logic [NCH-1:0]               ce_out
);

  localparam int CHW = chan_idx_w(NCH);

  logic             r_busy, r_ack;
  logic [CHW-1:0]   r_ch;
  logic [WIDTH-1:0] r_val;
  logic [NCH-1:0]   w_sel, w_bnd, w_apply;
  logic             w_ch_ok, w_fire;

  assign w_ch_ok = 32'(div_ch) < 32'(NCH);
  // A pending load lands at the target's period boundary, or immediately
  // on sync since every channel restarts there anyway.
  assign w_fire  = r_busy && (sync || |(w_bnd & w_sel));

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_ack  <= 1'b0;
      r_ch   <= '0;
      r_val  <= '0;
    end else begin
      r_ack <= w_fire;
      if (div_load && !r_busy && w_ch_ok) begin
        r_busy <= 1'b1;
        r_ch   <= div_ch;
        r_val  <= div_val;
      end else if (w_fire) begin
        r_busy <= 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    assign w_sel[gi]   = (r_ch == CHW'(gi));
    assign w_apply[gi] = w_fire & w_sel[gi];

    clk_div_chan #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk_in        (clk_in),
      .rst_n         (rst_n),
      .i_apply       (w_apply[gi]),
      .i_new_div     (r_val),
      .i_sync        (sync),
      .o_clk_out     (clk_out[gi]),
      .o_ce_out      (ce_out[gi]),
      .o_at_boundary (w_bnd[gi])
    );
  end

  assign div_busy = r_busy;
  assign div_ack  = r_ack;

endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: self-checking bench for clk_div_bank (NCH=4, WIDTH=13,
// DEFAULT_DIV=1). A behavioural model tracks each channel's position in its
// period and the single pending load; every cycle's outputs are compared.
module tb_clk_div_bank;

  localparam int NCH   = 4;
  localparam int WIDTH = 13;

  logic             clk_in, rst_n, div_load, sync;
  logic [1:0]       div_ch;
  logic [WIDTH-1:0] div_val;
  logic             div_busy, div_ack;
  logic [NCH-1:0]   clk_out, ce_out;

  clk_div_bank #(.NCH(NCH), .WIDTH(WIDTH), .DEFAULT_DIV(13'd1)) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .div_load (div_load),
    .div_ch   (div_ch),
    .div_val  (div_val),
    .div_busy (div_busy),
    .div_ack  (div_ack),
    .sync     (sync),
    .clk_out  (clk_out),
    .ce_out   (ce_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int             m_div [NCH];
  int             m_pos [NCH];
  bit             m_busy, m_ack;
  int             m_ch, m_val;
  bit [NCH-1:0]   m_clk, m_ce;

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_div[c] = 1;
      m_pos[c] = 0;
    end
    m_busy = 0; m_ack = 0; m_ch = 0; m_val = 0;
    m_clk = '0; m_ce = '0;
  endfunction

  function automatic bit last_of_period(input int c);
    return (m_div[c] <= 1) || (m_pos[c] == m_div[c] - 1);
  endfunction

  function automatic void model_step();
    bit fire;
    if (!rst_n) begin
      model_reset();
      return;
    end
    fire = m_busy && (sync || last_of_period(m_ch));
    for (int c = 0; c < NCH; c++) begin
      m_clk[c] = (m_div[c] > 0) && (m_pos[c] < (m_div[c] + 1) / 2);
      m_ce[c]  = (m_div[c] > 0) && (m_pos[c] == 0);
      if (fire && c == m_ch) begin
        m_div[c] = m_val;
        m_pos[c] = 0;
      end else if (sync || m_div[c] <= 1) begin
        m_pos[c] = 0;
      end else begin
        m_pos[c] = (m_pos[c] + 1) % m_div[c];
      end
    end
    m_ack = fire;
    if (div_load && !m_busy && int'(div_ch) < NCH) begin
      m_busy = 1;
      m_ch   = int'(div_ch);
      m_val  = int'(div_val);
    end else if (fire) begin
      m_busy = 0;
    end
  endfunction

  // One clock: model follows the edge, DUT is sampled on the falling edge.
  task automatic cycle();
    @(posedge clk_in);
    model_step();
    @(negedge clk_in);
    chk("clk_out",  32'(clk_out),  32'(m_clk));
    chk("ce_out",   32'(ce_out),   32'(m_ce));
    chk("div_busy", 32'(div_busy), 32'(m_busy));
    chk("div_ack",  32'(div_ack),  32'(m_ack));
  endtask

  task automatic do_load(input int ch, input int val);
    div_load = 1'b1;
    div_ch   = 2'(ch);
    div_val  = WIDTH'(val);
    cycle();
    div_load = 1'b0;
  endtask

  task automatic wait_ack(output int lat);
    lat = 0;
    do begin
      cycle();
      lat++;
    end while (div_ack !== 1'b1 && lat < 9000);
    chk("ack_seen", 32'(div_ack), 32'd1);
  endtask

  task automatic load_wait(input int ch, input int val, output int lat);
    do_load(ch, val);
    wait_ack(lat);
  endtask

  task automatic do_sync();
    sync = 1'b1;
    cycle();
    sync = 1'b0;
  endtask

  int c_ce [NCH];
  int c_hi [NCH];
  int c_ack;

  task automatic run_count(input int n);
    for (int c = 0; c < NCH; c++) begin
      c_ce[c] = 0;
      c_hi[c] = 0;
    end
    c_ack = 0;
    repeat (n) begin
      cycle();
      for (int c = 0; c < NCH; c++) begin
        c_ce[c] += int'(ce_out[c]);
        c_hi[c] += int'(clk_out[c]);
      end
      c_ack += int'(div_ack);
    end
  endtask

  typedef struct {
    int ch;
    int d_old;
    int d_new;
    int pos;
    int lat;
  } vec_t;

  vec_t tv [6];

  initial begin
    int lat, coin;
    int exp_ce [NCH];
    int exp_hi [NCH];

    // ack latency from capture: cnt<D-1 -> D-1-cnt; cnt=D-1 -> D; D<=1 -> 1
    tv[0] = '{ch: 2, d_old: 5, d_new: 7, pos: 1, lat: 3};
    tv[1] = '{ch: 0, d_old: 4, d_new: 2, pos: 0, lat: 3};
    tv[2] = '{ch: 1, d_old: 3, d_new: 6, pos: 2, lat: 3};
    tv[3] = '{ch: 3, d_old: 1, d_new: 5, pos: 0, lat: 1};
    tv[4] = '{ch: 1, d_old: 6, d_new: 1, pos: 4, lat: 1};
    tv[5] = '{ch: 0, d_old: 2, d_new: 5, pos: 1, lat: 2};

    rst_n = 1'b0; div_load = 1'b0; sync = 1'b0; div_ch = '0; div_val = '0;
    model_reset();

    // Reset state
    #1;
    chk("rst_clk_out",  32'(clk_out),  32'd0);
    chk("rst_ce_out",   32'(ce_out),   32'd0);
    chk("rst_div_busy", 32'(div_busy), 32'd0);
    chk("rst_div_ack",  32'(div_ack),  32'd0);
    repeat (2) cycle();
    @(negedge clk_in);
    rst_n = 1'b1;
    cycle();
    chk("first_clk_out", 32'(clk_out), 32'hF);
    chk("first_ce_out",  32'(ce_out),  32'hF);

    // Program 1,2,3,4 and measure steady-state periods over 12 cycles
    for (int c = 0; c < NCH; c++) load_wait(c, c + 1, lat);
    do_sync();
    run_count(12);
    exp_ce = '{12, 6, 4, 3};
    exp_hi = '{12, 6, 8, 6};
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("ce_count_ch%0d", c), 32'(c_ce[c]), 32'(exp_ce[c]));
      chk($sformatf("hi_count_ch%0d", c), 32'(c_hi[c]), 32'(exp_hi[c]));
    end

    // D=3,4,6 then sync: strobes coincide on the 2nd edge, again after 12
    load_wait(0, 3, lat);
    load_wait(1, 4, lat);
    load_wait(2, 6, lat);
    do_sync();
    cycle();
    chk("sync_align", 32'(ce_out[2:0]), 32'd7);
    coin = 0;
    repeat (11) begin
      cycle();
      if (ce_out[2:0] == 3'b111) coin++;
    end
    chk("sync_no_early_align", 32'(coin), 32'd0);
    cycle();
    chk("sync_lcm_align", 32'(ce_out[2:0]), 32'd7);

    // Load latency table
    for (int i = 0; i < 6; i++) begin
      load_wait(tv[i].ch, tv[i].d_old, lat);
      do_sync();
      repeat (tv[i].pos) cycle();
      load_wait(tv[i].ch, tv[i].d_new, lat);
      chk($sformatf("ack_lat_v%0d", i), 32'(lat), 32'(tv[i].lat));
    end
    run_count(14);
    chk("ch2_d7_ce", 32'(c_ce[2]), 32'd2);
    chk("ch2_d7_hi", 32'(c_hi[2]), 32'd8);

    // Second load while busy is dropped
    load_wait(1, 5, lat);
    do_sync();
    div_load = 1'b1; div_ch = 2'd1; div_val = 13'd9;
    cycle();
    chk("dbl_busy1", 32'(div_busy), 32'd1);
    div_val = 13'd2;
    cycle();
    div_load = 1'b0;
    chk("dbl_busy2", 32'(div_busy), 32'd1);
    wait_ack(lat);
    chk("dbl_lat", 32'(lat), 32'd3);
    chk("dbl_busy_clr", 32'(div_busy), 32'd0);
    run_count(18);
    chk("dbl_no_2nd_ack", 32'(c_ack), 32'd0);
    chk("dbl_ch1_ce", 32'(c_ce[1]), 32'd2);
    chk("dbl_ch1_hi", 32'(c_hi[1]), 32'd10);

    // D=0 disables, then D=2 restarts after one cycle
    load_wait(3, 0, lat);
    coin = 0;
    repeat (6) begin
      cycle();
      coin += int'(clk_out[3]) + int'(ce_out[3]);
    end
    chk("d0_quiet", 32'(coin), 32'd0);
    load_wait(3, 2, lat);
    chk("d0_to_d2_lat", 32'(lat), 32'd1);
    cycle();
    chk("d2_restart_ce", 32'(ce_out[3]), 32'd1);

    // Maximum divisor, then a pending load applied by sync
    load_wait(0, 8191, lat);
    do_sync();
    run_count(8191);
    chk("dmax_ce", 32'(c_ce[0]), 32'd1);
    chk("dmax_hi", 32'(c_hi[0]), 32'd4096);
    do_load(0, 1);
    chk("sync_pend_busy", 32'(div_busy), 32'd1);
    do_sync();
    chk("sync_pend_ack", 32'(div_ack), 32'd1);
    chk("sync_pend_busy_clr", 32'(div_busy), 32'd0);
    cycle();
    chk("sync_pend_d1_ce", 32'(ce_out[0]), 32'd1);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      div_load = ($urandom_range(0, 3) == 0);
      div_ch   = 2'($urandom_range(0, 3));
      div_val  = WIDTH'($urandom_range(0, 9));
      sync     = ($urandom_range(0, 31) == 0);
      cycle();
    end
    div_load = 1'b0; sync = 1'b0;

    // Reset while a load is pending
    load_wait(2, 7, lat);
    do_sync();
    do_load(2, 3);
    chk("mid_busy", 32'(div_busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_clk", 32'(clk_out),  32'd0);
    chk("mid_rst_ce",  32'(ce_out),   32'd0);
    chk("mid_rst_busy", 32'(div_busy), 32'd0);
    chk("mid_rst_ack", 32'(div_ack),  32'd0);
    model_reset();
    repeat (2) cycle();
    @(negedge clk_in);
    rst_n = 1'b1;
    run_count(10);
    chk("post_rst_no_ack", 32'(c_ack), 32'd0);
    for (int c = 0; c < NCH; c++)
      chk($sformatf("post_rst_ce_ch%0d", c), 32'(c_ce[c]), 32'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
